// File: rtl/isi_channel_fir.sv
// Linear ISI channel model: a TAPS-long FIR over PAM samples with a valid/ready stream,
// a two-stage pipeline and a drain/load/flush sequence for replacing the pulse response.
module isi_channel_fir #(
  parameter int TAPS              = 4,
  parameter int SIGNAL_RESOLUTION = 8,
  parameter int COEF_WIDTH        = 8,
  parameter int COEF_FRAC         = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
  input  logic                                signal_in_valid,
  output logic                                signal_in_ready,
  output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
  output logic                                signal_out_valid,
  input  logic                                signal_out_ready,
  input  logic                                cfg_start,
  input  logic                                coef_wr_en,
  input  logic        [$clog2(TAPS)-1:0]      coef_addr,
  input  logic signed [COEF_WIDTH-1:0]        coef_data,
  input  logic                                cfg_done,
  output logic                                busy,
  output logic        [15:0]                  sat_count
);
  localparam int SR    = SIGNAL_RESOLUTION;
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = SR + COEF_WIDTH;
  localparam int ACC_W = PW + AW;

  localparam logic signed [ACC_W-1:0]      RND      = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0]      OUT_MAX  = (ACC_W'(1) << (SR - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0]      OUT_MIN  = -(ACC_W'(1) << (SR - 1));
  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1) << COEF_FRAC;

  typedef enum logic [1:0] {RUN, DRAIN, LOAD, FLUSH} state_t;
  state_t state_q, state_d;

  logic signed [COEF_WIDTH-1:0] coef_q [TAPS];
  logic signed [SR-1:0]         hist_q [TAPS-1];
  logic signed [PW-1:0]         prod_q [TAPS];
  logic signed [PW-1:0]         prod_d [TAPS];
  logic                         s1_valid_q;
  logic signed [SR-1:0]         out_q;
  logic                         out_valid_q;
  logic                         out_sat_q;
  logic [15:0]                  sat_cnt_q;

  logic advance, in_fire, out_fire;
  assign advance         = !out_valid_q || signal_out_ready;
  assign signal_in_ready = advance && (state_q == RUN) && !rst;
  assign in_fire         = signal_in_valid && signal_in_ready;
  assign out_fire        = out_valid_q && signal_out_ready;

  assign signal_out       = out_q;
  assign signal_out_valid = out_valid_q;
  assign busy             = (state_q != RUN);
  assign sat_count        = sat_cnt_q;

  // Tap 0 multiplies the sample being accepted; tap k the (k-1)-th stored one.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_prod
      logic signed [SR-1:0] tap_x;
      if (gi == 0) begin : g_new
        assign tap_x = signal_in;
      end else begin : g_old
        assign tap_x = hist_q[gi-1];
      end
      assign prod_d[gi] = PW'(tap_x) * PW'(coef_q[gi]);
    end
  endgenerate

  logic signed [ACC_W-1:0] acc_sum, acc_rnd, acc_shr;
  logic signed [SR-1:0]    sat_val;
  logic                    sat_flag;

  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc_sum = acc_sum + ACC_W'(prod_q[k]);
    end
    acc_rnd  = acc_sum + RND;
    acc_shr  = acc_rnd >>> COEF_FRAC;
    sat_flag = 1'b0;
    sat_val  = SR'(acc_shr);
    if (acc_shr > OUT_MAX) begin
      sat_val  = SR'(OUT_MAX);
      sat_flag = 1'b1;
    end else if (acc_shr < OUT_MIN) begin
      sat_val  = SR'(OUT_MIN);
      sat_flag = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (cfg_start) state_d = DRAIN;
      DRAIN:   if (!s1_valid_q && !out_valid_q) state_d = LOAD;
      LOAD:    if (cfg_done) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      sat_cnt_q   <= '0;
      for (int k = 0; k < TAPS - 1; k++) hist_q[k] <= '0;
      for (int k = 0; k < TAPS; k++) begin
        prod_q[k] <= '0;
        coef_q[k] <= (k == 0) ? COEF_ONE : '0;
      end
    end else begin
      state_q <= state_d;

      if (state_q == FLUSH) begin
        for (int k = 0; k < TAPS - 1; k++) hist_q[k] <= '0;
      end else if (in_fire) begin
        hist_q[0] <= signal_in;
        for (int k = TAPS - 2; k > 0; k--) hist_q[k] <= hist_q[k-1];
      end

      // Addresses beyond the last tap match no entry and are dropped.
      if (state_q == LOAD && coef_wr_en) begin
        for (int k = 0; k < TAPS; k++) begin
          if (coef_addr == AW'(k)) coef_q[k] <= coef_data;
        end
      end

      if (advance) begin
        s1_valid_q  <= in_fire;
        out_valid_q <= s1_valid_q;
        if (in_fire) begin
          for (int k = 0; k < TAPS; k++) prod_q[k] <= prod_d[k];
        end
        if (s1_valid_q) begin
          out_q     <= sat_val;
          out_sat_q <= sat_flag;
        end
      end

      if (state_q == FLUSH) begin
        sat_cnt_q <= '0;
      end else if (out_fire && out_sat_q && sat_cnt_q != 16'hFFFF) begin
        sat_cnt_q <= sat_cnt_q + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_isi_channel_fir.sv
// Bench for isi_channel_fir: integer reference model of the channel plus directed
// vectors with hand-computed results for identity, ISI, saturation, rounding and control.
module tb_isi_channel_fir;
  localparam int TAPS = 4;
  localparam int SR   = 8;
  localparam int CW   = 8;
  localparam int CF   = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [SR-1:0] signal_in;
  logic                 signal_in_valid;
  logic                 signal_in_ready;
  logic signed [SR-1:0] signal_out;
  logic                 signal_out_valid;
  logic                 signal_out_ready;
  logic                 cfg_start;
  logic                 coef_wr_en;
  logic [1:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 cfg_done;
  logic                 busy;
  logic [15:0]          sat_count;

  isi_channel_fir #(
    .TAPS(TAPS), .SIGNAL_RESOLUTION(SR), .COEF_WIDTH(CW), .COEF_FRAC(CF)
  ) dut (
    .clk(clk), .rst(rst),
    .signal_in(signal_in), .signal_in_valid(signal_in_valid), .signal_in_ready(signal_in_ready),
    .signal_out(signal_out), .signal_out_valid(signal_out_valid), .signal_out_ready(signal_out_ready),
    .cfg_start(cfg_start), .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
    .cfg_done(cfg_done), .busy(busy), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_h [TAPS];
  int m_x [TAPS];
  int m_sat = 0;
  int exp_q[$];
  bit sat_q[$];
  int acc_q[$];
  int got_q[$];
  int lat_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: y = clamp(floor((sum h[k]*x[n-k] + 2^(CF-1)) / 2^CF))
  function automatic void model_accept(input int x);
    int s = 0;
    int r;
    bit sat = 1'b0;
    for (int k = TAPS - 1; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = x;
    for (int k = 0; k < TAPS; k++) s += m_h[k] * m_x[k];
    r = (s + (1 << (CF - 1))) >>> CF;
    if (r > (2 ** (SR - 1)) - 1) begin
      r = (2 ** (SR - 1)) - 1;
      sat = 1'b1;
    end else if (r < -(2 ** (SR - 1))) begin
      r = -(2 ** (SR - 1));
      sat = 1'b1;
    end
    exp_q.push_back(r);
    sat_q.push_back(sat);
    acc_q.push_back(cyc);
  endfunction

  always @(negedge clk) begin
    int e;
    int a;
    bit s;
    cyc++;
    if (!rst) begin
      chk("sat_count", int'(sat_count), m_sat);
      if (signal_out_valid && signal_out_ready) begin
        chk("out_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          s = sat_q.pop_front();
          a = acc_q.pop_front();
          chk("signal_out", int'(signal_out), e);
          got_q.push_back(int'(signal_out));
          lat_q.push_back(cyc - a);
          if (s && m_sat < 65535) m_sat++;
        end
      end
      if (signal_in_valid && signal_in_ready) model_accept(int'(signal_in));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    int n = 0;
    signal_in = SR'(v);
    signal_in_valid = 1'b1;
    @(negedge clk);
    while (!signal_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", int'(n < 50), 1);
    @(posedge clk);
    #1;
    signal_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || signal_out_valid) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_timeout", int'(n < 100), 1);
  endtask

  task automatic check_got(input string name, input int n, input int e0, input int e1,
                           input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk(name, got_q[i], e[i]);
    got_q.delete();
    lat_q.delete();
  endtask

  task automatic begin_load();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk("busy_drain", int'(busy), 1);
    chk("in_ready_drain", int'(signal_in_ready), 0);
    wait_drain();
    tick();
    tick();
    chk("busy_load", int'(busy), 1);
  endtask

  task automatic write_coef(input int a, input int d);
    coef_wr_en = 1'b1;
    coef_addr  = 2'(a);
    coef_data  = CW'(d);
    tick();
    coef_wr_en = 1'b0;
  endtask

  task automatic end_load(input int a, input int d);
    coef_wr_en = 1'b1;
    coef_addr  = 2'(a);
    coef_data  = CW'(d);
    cfg_done   = 1'b1;
    tick();
    coef_wr_en = 1'b0;
    cfg_done   = 1'b0;
    chk("busy_flush", int'(busy), 1);
    tick();
    chk("busy_run", int'(busy), 0);
    for (int k = 0; k < TAPS; k++) m_x[k] = 0;
    m_sat = 0;
  endtask

  task automatic load_coefs(input int c0, input int c1, input int c2, input int c3);
    begin_load();
    write_coef(0, c0);
    write_coef(1, c1);
    write_coef(2, c2);
    end_load(3, c3);
    m_h = '{c0, c1, c2, c3};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    signal_in_valid = 1'b0;
    exp_q.delete();
    sat_q.delete();
    acc_q.delete();
    got_q.delete();
    lat_q.delete();
    for (int k = 0; k < TAPS; k++) begin
      m_x[k] = 0;
      m_h[k] = (k == 0) ? (1 << CF) : 0;
    end
    m_sat = 0;
    #1;
    chk("rst_out_valid", int'(signal_out_valid), 0);
    chk("rst_out", int'(signal_out), 0);
    chk("rst_in_ready", int'(signal_in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sat_count", int'(sat_count), 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int held;
    rst = 1'b1;
    signal_in = '0;
    signal_in_valid = 1'b0;
    signal_out_ready = 1'b1;
    cfg_start = 1'b0;
    coef_wr_en = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    cfg_done = 1'b0;
    tick();
    do_reset();
    tick();

    // Identity channel after reset, 2-cycle latency
    send(56);
    send(-16);
    wait_drain();
    chk("latency", (lat_q.size() > 0) ? lat_q[0] : -1, 2);
    check_got("identity", 2, 56, -16, 0, 0);

    // Channel [1, 0.5]
    load_coefs(64, 32, 0, 0);
    send(56); send(56); send(0); send(0);
    wait_drain();
    check_got("isi", 4, 56, 84, 28, 0);

    // Saturation both ways, sat_count cleared by the reload flush
    load_coefs(64, 64, 0, 0);
    send(100); send(100);
    wait_drain();
    check_got("sat_pos", 2, 100, 127, 0, 0);
    chk("sat_count_pos", int'(sat_count), 1);
    load_coefs(64, 64, 0, 0);
    chk("sat_count_flushed", int'(sat_count), 0);
    send(-100); send(-100);
    wait_drain();
    check_got("sat_neg", 2, -100, -128, 0, 0);
    chk("sat_count_neg", int'(sat_count), 1);

    // Round half up
    load_coefs(32, 0, 0, 0);
    send(3); send(-3); send(1);
    wait_drain();
    check_got("round", 3, 2, -1, 1, 0);

    // Backpressure for 3 cycles
    fork
      begin
        send(10); send(20); send(30); send(40);
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!signal_out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_wait", int'(n < 50), 1);
        @(posedge clk);
        #1;
        signal_out_ready = 1'b0;
        @(negedge clk);
        held = int'(signal_out);
        for (int i = 0; i < 3; i++) begin
          chk("stall_out_valid", int'(signal_out_valid), 1);
          chk("stall_in_ready", int'(signal_in_ready), 0);
          if (i > 0) chk("stall_out_stable", int'(signal_out), held);
          if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        signal_out_ready = 1'b1;
      end
    join
    wait_drain();
    check_got("backpressure", 4, 5, 10, 15, 20);

    // Reload requested with two samples in flight
    send(50);
    send(-50);
    load_coefs(64, 0, 0, 0);
    check_got("drain_before_load", 2, 25, -25, 0, 0);

    // Coefficient write outside LOAD has no effect
    write_coef(0, 0);
    send(7);
    wait_drain();
    check_got("wr_outside_load", 1, 7, 0, 0, 0);

    // Reset mid-stream restores identity taps
    load_coefs(32, 64, 0, 0);
    send(100);
    send(100);
    do_reset();
    tick();
    send(56);
    send(20);
    wait_drain();
    check_got("reset_stream", 2, 56, 20, 0, 0);

    // Reset mid-load discards partial writes
    begin_load();
    write_coef(0, 16);
    do_reset();
    tick();
    send(40);
    wait_drain();
    check_got("reset_load", 1, 40, 0, 0, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
